// File: rtl/energy_pkg.sv
// energy_pkg: shared state type, counter width and generic saturating add
package energy_pkg;
  typedef enum logic {ACCUM, EMIT} state_t;
  localparam int CNTW = 16;
  localparam int MAXW = 64;
  // Operands arrive sign-extended to MAXW; w is the real width to clamp at.
  function automatic logic [MAXW:0] sat_add(input logic signed [MAXW-1:0] a, input logic signed [MAXW-1:0] b, input int w);
    logic signed [MAXW:0] s, mx;
    s = {a[MAXW-1], a} + {b[MAXW-1], b};
    mx = ((MAXW+1)'(1) << (w - 1)) - (MAXW+1)'(1);
    return s > mx ? {1'b1, mx[MAXW-1:0]} : s < ~mx ? {1'b1, ~mx[MAXW-1:0]} : {1'b0, s[MAXW-1:0]};
  endfunction
endpackage

// File: rtl/energy_accum_if.sv
// energy_accum_if: sample input stream, flush and frame result stream
interface energy_accum_if import energy_pkg::*; #(parameter int INW = 32, parameter int ACCW = 48);
  logic in_valid, in_ready, flush, out_valid, out_ready, out_sat;
  logic signed [INW-1:0] in_data;
  logic signed [ACCW-1:0] out_sum;
  logic [CNTW-1:0] out_count;
  modport master(output in_valid, in_data, flush, out_ready, input in_ready, out_valid, out_sum, out_count, out_sat);
  modport slave(input in_valid, in_data, flush, out_ready, output in_ready, out_valid, out_sum, out_count, out_sat);
endinterface

// File: rtl/energy_sat_add.sv
// energy_sat_add: ACCW-bit signed saturating adder with overflow flag
module energy_sat_add import energy_pkg::*; #(parameter int ACCW = 48) (
  input  logic signed [ACCW-1:0] i_a,
  input  logic signed [ACCW-1:0] i_b,
  output logic signed [ACCW-1:0] o_sum,
  output logic                   o_ovf
);
  logic signed [MAXW-1:0] w_a, w_b;
  logic [MAXW:0] w_r;
  assign w_a = MAXW'(i_a);
  assign w_b = MAXW'(i_b);
  assign w_r = sat_add(w_a, w_b, ACCW);
  assign o_sum = w_r[ACCW-1:0];
  // The upper bits are always a sign extension of o_sum; folding them in keeps every result bit consumed.
  assign o_ovf = w_r[MAXW] | (w_r[MAXW-1:0] != MAXW'(o_sum));
endmodule

// File: rtl/energy_accum.sv
// energy_accum: per-frame saturating energy sum with flush and ready/valid result
module energy_accum import energy_pkg::*; #(
  parameter int INW = 32,
  parameter int ACCW = 48,
  parameter int FRAME_LEN = 16
) (
  input logic clk,
  input logic rst_n,
  energy_accum_if.slave bus
);
  state_t r_state, w_next;
  logic signed [ACCW-1:0] r_acc, r_sum, w_x, w_sum, w_nsum;
  logic [CNTW-1:0] r_cnt, r_ocnt, w_ncnt;
  logic r_sat, r_osat, r_valid, w_ovf, w_acc, w_nsat, w_close;
  assign w_x = ACCW'(bus.in_data);
  energy_sat_add #(.ACCW(ACCW)) u_add (.i_a(r_acc), .i_b(w_x), .o_sum(w_sum), .o_ovf(w_ovf));
  always_comb begin
    w_acc = (r_state == ACCUM) && bus.in_valid;
    w_ncnt = w_acc ? r_cnt + 1'b1 : r_cnt;
    w_nsum = w_acc ? w_sum : r_acc;
    w_nsat = r_sat | (w_acc & w_ovf);
    // A flush only closes a frame that holds at least one beat, counting this cycle's.
    w_close = (r_state == ACCUM) && ((w_acc && w_ncnt == CNTW'(FRAME_LEN)) || (bus.flush && w_ncnt != '0));
    w_next = w_close ? EMIT : (r_state == EMIT && bus.out_ready) ? ACCUM : r_state;
  end
  always_ff @(posedge clk)
    r_state <= !rst_n ? ACCUM : w_next;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_sum <= '0;
      r_ocnt <= '0;
      r_osat <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_acc <= w_close ? '0 : w_nsum;
      r_cnt <= w_close ? '0 : w_ncnt;
      r_sat <= !w_close && w_nsat;
      r_sum <= w_close ? w_nsum : r_sum;
      r_ocnt <= w_close ? w_ncnt : r_ocnt;
      r_osat <= w_close ? w_nsat : r_osat;
      r_valid <= w_close | (r_valid & !bus.out_ready);
    end
  end
  assign bus.in_ready = (r_state == ACCUM);
  assign bus.out_valid = r_valid;
  assign bus.out_sum = r_sum;
  assign bus.out_count = r_ocnt;
  assign bus.out_sat = r_osat;
endmodule

// File: tb/tb_energy_accum.sv
// tb_energy_accum: directed scoreboard bench over three energy_accum configurations
module tb_energy_accum;
  typedef struct {logic [63:0] sum; logic [15:0] cnt; logic sat;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic iv [3], fl [3], ordy [3], ir [3], ov [3], osat [3];
  logic [31:0] idata = '0;
  logic [63:0] osum [3];
  logic [15:0] ocnt [3];
  exp_t q [$];
  int n_pass = 0, n_tot = 0;
  energy_accum_if #(.INW(32), .ACCW(48)) a_if ();
  energy_accum_if #(.INW(32), .ACCW(48)) b_if ();
  energy_accum_if #(.INW(32), .ACCW(34)) c_if ();
  energy_accum #(.INW(32), .ACCW(48), .FRAME_LEN(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  energy_accum #(.INW(32), .ACCW(48), .FRAME_LEN(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  energy_accum #(.INW(32), .ACCW(34), .FRAME_LEN(8)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));
  assign a_if.in_valid = iv[0];
  assign b_if.in_valid = iv[1];
  assign c_if.in_valid = iv[2];
  assign a_if.flush = fl[0];
  assign b_if.flush = fl[1];
  assign c_if.flush = fl[2];
  assign a_if.out_ready = ordy[0];
  assign b_if.out_ready = ordy[1];
  assign c_if.out_ready = ordy[2];
  assign a_if.in_data = idata;
  assign b_if.in_data = idata;
  assign c_if.in_data = idata;
  assign ir[0] = a_if.in_ready;
  assign ir[1] = b_if.in_ready;
  assign ir[2] = c_if.in_ready;
  assign ov[0] = a_if.out_valid;
  assign ov[1] = b_if.out_valid;
  assign ov[2] = c_if.out_valid;
  assign osum[0] = 64'(a_if.out_sum);
  assign osum[1] = 64'(b_if.out_sum);
  assign osum[2] = 64'(c_if.out_sum);
  assign ocnt[0] = a_if.out_count;
  assign ocnt[1] = b_if.out_count;
  assign ocnt[2] = c_if.out_count;
  assign osat[0] = a_if.out_sat;
  assign osat[1] = b_if.out_sat;
  assign osat[2] = c_if.out_sat;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic beat(input int s, input logic [31:0] d, input logic f);
    iv[s] = 1'b1;
    idata = d;
    fl[s] = f;
    @(posedge clk);
    #1;
    iv[s] = 1'b0;
    fl[s] = 1'b0;
  endtask
  task automatic flush_only(input int s);
    fl[s] = 1'b1;
    @(posedge clk);
    #1;
    fl[s] = 1'b0;
  endtask
  task automatic push(input logic [63:0] sum, input logic [15:0] cnt, input logic sat);
    exp_t e;
    e.sum = sum;
    e.cnt = cnt;
    e.sat = sat;
    q.push_back(e);
  endtask
  task automatic take(input int s, input string tag);
    exp_t e;
    int n = 0;
    while (!ov[s] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, 64'(ov[s]), 64'd1);
    chk({tag, "_sb_empty"}, 64'(q.size() == 0), 64'd0);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_sum"}, osum[s], e.sum);
      chk({tag, "_count"}, 64'(ocnt[s]), 64'(e.cnt));
      chk({tag, "_sat"}, 64'(osat[s]), 64'(e.sat));
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      fl[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 64'(ir[i]), 64'd1);
      chk("rst_out_valid", 64'(ov[i]), 64'd0);
      chk("rst_out_sum", osum[i], 64'd0);
      chk("rst_out_count", 64'(ocnt[i]), 64'd0);
      chk("rst_out_sat", 64'(osat[i]), 64'd0);
    end
    // Full frame, downstream always ready
    beat(0, 32'd1, 1'b0);
    beat(0, 32'd4, 1'b0);
    beat(0, 32'd9, 1'b0);
    beat(0, 32'd16, 1'b0);
    push(64'd30, 16'd4, 1'b0);
    chk("t1_valid_lat", 64'(ov[0]), 64'd1);
    chk("t1_ready_low", 64'(ir[0]), 64'd0);
    take(0, "t1");
    @(posedge clk);
    #1;
    chk("t1_valid_drop", 64'(ov[0]), 64'd0);
    chk("t1_ready_back", 64'(ir[0]), 64'd1);
    // Backpressure during EMIT
    ordy[0] = 1'b0;
    beat(0, 32'd2, 1'b0);
    beat(0, 32'd3, 1'b0);
    beat(0, 32'd4, 1'b0);
    beat(0, 32'd5, 1'b0);
    push(64'd14, 16'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 64'(ov[0]), 64'd1);
      chk("t2_hold_ready", 64'(ir[0]), 64'd0);
      chk("t2_hold_sum", osum[0], 64'd14);
      chk("t2_hold_count", 64'(ocnt[0]), 64'd4);
      @(posedge clk);
      #1;
    end
    ordy[0] = 1'b1;
    take(0, "t2");
    @(posedge clk);
    #1;
    chk("t2_done", 64'(ov[0]), 64'd0);
    // Flush variants
    beat(1, 32'd25, 1'b0);
    beat(1, 32'd36, 1'b0);
    flush_only(1);
    push(64'd61, 16'd2, 1'b0);
    take(1, "t3a");
    @(posedge clk);
    #1;
    beat(1, 32'd25, 1'b0);
    beat(1, 32'd36, 1'b0);
    beat(1, 32'd49, 1'b1);
    push(64'd110, 16'd3, 1'b0);
    take(1, "t3b");
    @(posedge clk);
    #1;
    flush_only(1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_empty_flush", 64'(ov[1]), 64'd0);
      chk("t3_empty_ready", 64'(ir[1]), 64'd1);
      @(posedge clk);
      #1;
    end
    // Positive and negative clamp at ACCW=34
    for (int i = 0; i < 8; i++) beat(2, 32'h7FFF_FFFF, 1'b0);
    push(64'h1_FFFF_FFFF, 16'd8, 1'b1);
    take(2, "t4_pos");
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) beat(2, 32'd1, 1'b0);
    push(64'd8, 16'd8, 1'b0);
    take(2, "t4_clean");
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) beat(2, 32'h8000_0000, 1'b0);
    push(64'hFFFF_FFFE_0000_0000, 16'd8, 1'b1);
    take(2, "t4_neg");
    @(posedge clk);
    #1;
    // Signed inputs
    beat(0, 32'hFFFF_FFFB, 1'b0);
    beat(0, 32'd3, 1'b0);
    flush_only(0);
    push(64'hFFFF_FFFF_FFFF_FFFE, 16'd2, 1'b0);
    take(0, "t5");
    @(posedge clk);
    #1;
    // Reset discards a partial frame
    beat(0, 32'd7, 1'b0);
    beat(0, 32'd7, 1'b0);
    beat(0, 32'd7, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_ready", 64'(ir[0]), 64'd1);
    chk("t6_valid", 64'(ov[0]), 64'd0);
    chk("t6_sum", osum[0], 64'd0);
    for (int i = 0; i < 4; i++) beat(0, 32'd2, 1'b0);
    push(64'd8, 16'd4, 1'b0);
    take(0, "t6");
    @(posedge clk);
    #1;
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
